dw_mac_cfu: RTL and testbench

- Parametrised depthwise-convolution MAC custom function unit that succeeds the fixed CFU shell.
- Accepts CPU custom-instruction commands carrying packed int8 activations and weights.
- Performs SIMD offset-multiply-accumulate into a bank of per-channel accumulators, with a 2-cycle MAC pipeline and an explicit ready/valid handshake.
- Sits between the VexRiscv CFU bus and the depthwise 5x5 conv kernel loop in software.

---
 rtl/dw_cfu_pkg.sv | 24 ++
 rtl/dw_mac_lanes.sv | 26 ++
 rtl/dw_mac_cfu.sv | 95 +++++++++
 tb/tb_dw_mac_cfu.sv | 128 ++++++++++++
 4 files changed

// File: rtl/dw_cfu_pkg.sv
// dw_cfu_pkg: opcodes, lane widths, FSM states and the lane offset-multiply helper for dw_mac_cfu.
package dw_cfu_pkg;
  localparam int LANE_W = 8;
  localparam int OFF_W = 9;
  localparam int ADD_W = 10;
  localparam int PROD_W = 18;
  typedef enum logic [6:0] {
    NOP = 7'd0,
    CLR = 7'd1,
    SET_OFFSET = 7'd2,
    SET_SEL = 7'd3,
    MAC = 7'd4,
    READ_ACC = 7'd5,
    READ_TAPS = 7'd6
  } cmd_e;
  typedef enum logic {IDLE, MAC_S1} state_e;
  function automatic logic signed [PROD_W-1:0] lane_term(input logic signed [LANE_W-1:0] a,
                                                         input logic signed [LANE_W-1:0] w,
                                                         input logic signed [OFF_W-1:0] off);
    logic signed [ADD_W-1:0] s;
    s = ADD_W'(a) + ADD_W'(off);
    return PROD_W'(s) * PROD_W'(w);
  endfunction
endpackage

// File: rtl/dw_mac_lanes.sv
// dw_mac_lanes: SIMD offset-multiply lanes and adder tree, registered as MAC stage 1.
module dw_mac_lanes
  import dw_cfu_pkg::*;
#(
  parameter int BYTE_SIZE = 8,
  parameter int NUM_LANES = 4,
  parameter int ACC_WIDTH = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              load,
  input  logic [NUM_LANES*BYTE_SIZE-1:0]    act,
  input  logic [NUM_LANES*BYTE_SIZE-1:0]    wgt,
  input  logic signed [OFF_W-1:0]           offset,
  output logic signed [ACC_WIDTH-1:0]       sum
);
  logic signed [ACC_WIDTH-1:0] tree;
  always_comb begin
    tree = '0;
    for (int i = 0; i < NUM_LANES; i++)
      tree += ACC_WIDTH'(lane_term(act[i*BYTE_SIZE+:BYTE_SIZE], wgt[i*BYTE_SIZE+:BYTE_SIZE], offset));
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) sum <= '0;
    else if (load) sum <= tree;
endmodule

// File: rtl/dw_mac_cfu.sv
// dw_mac_cfu: depthwise-conv MAC custom function unit with per-channel accumulator bank.
// MACs take two edges (lane products, then accumulate); other commands complete on acceptance.
module dw_mac_cfu
  import dw_cfu_pkg::*;
#(
  parameter int BYTE_SIZE = 8,
  parameter int INT32_SIZE = 32,
  parameter int NUM_LANES = 4,
  parameter int NUM_ACC = 4,
  parameter int ACC_WIDTH = 32,
  parameter int KERNEL_TAPS = 25,
  parameter int TAP_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [6:0]            cmd,
  input  logic [INT32_SIZE-1:0] inp0,
  input  logic [INT32_SIZE-1:0] inp1,
  output logic [INT32_SIZE-1:0] ret,
  output logic                  output_buffer_valid,
  output logic                  ready
);
  localparam int SEL_W = $clog2(NUM_ACC);
  state_e state;
  logic signed [ACC_WIDTH-1:0] acc [NUM_ACC];
  logic signed [ACC_WIDTH-1:0] mac_sum, acc_new;
  logic signed [OFF_W-1:0] offset;
  logic [SEL_W-1:0] sel;
  logic [TAP_WIDTH-1:0] tap_cnt;
  logic [INT32_SIZE-1:0] taps_word;
  logic accept, mac_go;
  assign accept = en && ready;
  assign mac_go = accept && cmd == MAC;
  assign acc_new = acc[sel] + mac_sum;
  always_comb begin
    taps_word = '0;
    taps_word[TAP_WIDTH-1:0] = tap_cnt;
    taps_word[INT32_SIZE-1] = tap_cnt >= TAP_WIDTH'(KERNEL_TAPS);
  end
  dw_mac_lanes #(
    .BYTE_SIZE(BYTE_SIZE),
    .NUM_LANES(NUM_LANES),
    .ACC_WIDTH(ACC_WIDTH)
  ) u_lanes (
    .clk(clk),
    .rst(rst),
    .load(mac_go),
    .act(inp0[NUM_LANES*BYTE_SIZE-1:0]),
    .wgt(inp1[NUM_LANES*BYTE_SIZE-1:0]),
    .offset(offset),
    .sum(mac_sum)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ret <= '0;
      output_buffer_valid <= 1'b1;
      ready <= 1'b1;
      offset <= '0;
      sel <= '0;
      tap_cnt <= '0;
      for (int i = 0; i < NUM_ACC; i++) acc[i] <= '0;
    end else if (state == MAC_S1) begin
      acc[sel] <= acc_new;
      ret <= INT32_SIZE'(acc_new);
      tap_cnt <= tap_cnt + 1'b1;
      state <= IDLE;
      ready <= 1'b1;
      output_buffer_valid <= 1'b1;
    end else if (accept) begin
      ret <= '0;
      case (cmd)
        CLR: begin
          acc[sel] <= '0;
          tap_cnt <= '0;
        end
        SET_OFFSET: offset <= inp0[OFF_W-1:0];
        SET_SEL: begin
          sel <= inp0[SEL_W-1:0];
          tap_cnt <= '0;
        end
        MAC: begin
          ret <= ret;
          state <= MAC_S1;
          ready <= 1'b0;
          output_buffer_valid <= 1'b0;
        end
        READ_ACC: ret <= INT32_SIZE'(acc[inp0[SEL_W-1:0]]);
        READ_TAPS: ret <= taps_word;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_dw_mac_cfu.sv
// tb_dw_mac_cfu: directed-vector bench for dw_mac_cfu with hand-computed expectations.
module tb_dw_mac_cfu;
  import dw_cfu_pkg::*;
  logic clk = 0, rst = 1, en = 0;
  logic [6:0] cmd = 0;
  logic [31:0] inp0 = 0, inp1 = 0, ret;
  logic output_buffer_valid, ready;
  int tests = 0, fails = 0;

  dw_mac_cfu dut (
    .clk(clk), .rst(rst), .en(en), .cmd(cmd), .inp0(inp0), .inp1(inp1),
    .ret(ret), .output_buffer_valid(output_buffer_valid), .ready(ready)
  );

  always #5 clk = ~clk;

  task automatic do_cmd(input logic [6:0] c, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    en = 1; cmd = c; inp0 = a; inp1 = b;
    @(posedge clk);
    #1 en = 0;
  endtask

  task automatic do_mac(input logic [31:0] a, input logic [31:0] b);
    do_cmd(MAC, a, b);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #12;
    tests++; if (ret !== 32'h0) begin fails++; $display("FAIL rst_ret got %h exp %h", ret, 32'h0); end
    tests++; if (ready !== 1'b1) begin fails++; $display("FAIL rst_ready got %b exp 1", ready); end
    tests++; if (output_buffer_valid !== 1'b1) begin fails++; $display("FAIL rst_obv got %b exp 1", output_buffer_valid); end
    @(negedge clk) rst = 0;
    do_cmd(READ_ACC, 32'd0, 32'd0);
    tests++; if (ret !== 32'h0) begin fails++; $display("FAIL read0_ret got %h exp %h", ret, 32'h0); end
    tests++; if (output_buffer_valid !== 1'b1 || ready !== 1'b1) begin fails++; $display("FAIL read0_hs got obv=%b rdy=%b exp 1 1", output_buffer_valid, ready); end
  endtask

  task automatic test_mac_basic;
    do_cmd(MAC, 32'h01020304, 32'h01010101);
    tests++; if (ready !== 1'b0 || output_buffer_valid !== 1'b0) begin fails++; $display("FAIL mac_e0_hs got rdy=%b obv=%b exp 0 0", ready, output_buffer_valid); end
    @(posedge clk); #1;
    tests++; if (ret !== 32'h0000000A) begin fails++; $display("FAIL mac1_ret got %h exp %h", ret, 32'h0000000A); end
    tests++; if (ready !== 1'b1 || output_buffer_valid !== 1'b1) begin fails++; $display("FAIL mac_e1_hs got rdy=%b obv=%b exp 1 1", ready, output_buffer_valid); end
    do_mac(32'h01020304, 32'h01010101);
    tests++; if (ret !== 32'h00000014) begin fails++; $display("FAIL mac2_ret got %h exp %h", ret, 32'h00000014); end
    do_cmd(READ_TAPS, 32'd0, 32'd0);
    tests++; if (ret !== 32'h00000002) begin fails++; $display("FAIL taps2 got %h exp %h", ret, 32'h00000002); end
  endtask

  task automatic test_offset;
    do_cmd(CLR, 32'd0, 32'd0);
    tests++; if (ret !== 32'h0) begin fails++; $display("FAIL clr_ret got %h exp %h", ret, 32'h0); end
    do_cmd(SET_OFFSET, 32'd128, 32'd0);
    do_mac(32'h80808080, 32'h7F7F7F7F);
    tests++; if (ret !== 32'h0) begin fails++; $display("FAIL off128_ret got %h exp %h", ret, 32'h0); end
    do_cmd(CLR, 32'd0, 32'd0);
    do_cmd(SET_OFFSET, 32'hFFFFFF80, 32'd0);
    do_mac(32'h7F7F7F7F, 32'h01010101);
    tests++; if (ret !== 32'hFFFFFFFC) begin fails++; $display("FAIL offneg_ret got %h exp %h", ret, 32'hFFFFFFFC); end
    do_cmd(CLR, 32'd0, 32'd0);
    do_cmd(SET_OFFSET, 32'd0, 32'd0);
    do_mac(32'hFFFFFFFF, 32'h02020202);
    tests++; if (ret !== 32'hFFFFFFF8) begin fails++; $display("FAIL neg_ret got %h exp %h", ret, 32'hFFFFFFF8); end
  endtask

  task automatic test_sel_taps;
    do_cmd(SET_SEL, 32'd2, 32'd0);
    for (int k = 0; k < 24; k++) do_mac(32'h01010101, 32'h01010101);
    do_cmd(READ_TAPS, 32'd0, 32'd0);
    tests++; if (ret !== 32'h00000018) begin fails++; $display("FAIL taps24 got %h exp %h", ret, 32'h00000018); end
    do_mac(32'h01010101, 32'h01010101);
    tests++; if (ret !== 32'd100) begin fails++; $display("FAIL mac25_ret got %h exp %h", ret, 32'd100); end
    do_cmd(READ_ACC, 32'd2, 32'd0);
    tests++; if (ret !== 32'd100) begin fails++; $display("FAIL acc2 got %h exp %h", ret, 32'd100); end
    do_cmd(7'h7F, 32'd2, 32'd0);
    tests++; if (ret !== 32'h0) begin fails++; $display("FAIL badop_ret got %h exp %h", ret, 32'h0); end
    do_cmd(READ_ACC, 32'd0, 32'd0);
    tests++; if (ret !== 32'hFFFFFFF8) begin fails++; $display("FAIL acc0_kept got %h exp %h", ret, 32'hFFFFFFF8); end
    do_cmd(READ_TAPS, 32'd0, 32'd0);
    tests++; if (ret !== 32'h80000019) begin fails++; $display("FAIL taps25 got %h exp %h", ret, 32'h80000019); end
  endtask

  task automatic test_back_to_back;
    do_cmd(MAC, 32'h01010101, 32'h01010101);
    @(negedge clk);
    en = 1; cmd = CLR; inp0 = 0; inp1 = 0;
    @(posedge clk);
    #1 en = 0;
    tests++; if (ret !== 32'd104) begin fails++; $display("FAIL busy_mac_ret got %h exp %h", ret, 32'd104); end
    do_cmd(READ_ACC, 32'd2, 32'd0);
    tests++; if (ret !== 32'd104) begin fails++; $display("FAIL busy_acc2 got %h exp %h", ret, 32'd104); end
    do_cmd(READ_TAPS, 32'd0, 32'd0);
    tests++; if (ret !== 32'h8000001A) begin fails++; $display("FAIL busy_taps got %h exp %h", ret, 32'h8000001A); end
  endtask

  task automatic test_async_reset;
    do_cmd(MAC, 32'h05050505, 32'h03030303);
    #2 rst = 1;
    #1;
    tests++; if (ret !== 32'h0) begin fails++; $display("FAIL arst_ret got %h exp %h", ret, 32'h0); end
    tests++; if (ready !== 1'b1 || output_buffer_valid !== 1'b1) begin fails++; $display("FAIL arst_hs got rdy=%b obv=%b exp 1 1", ready, output_buffer_valid); end
    @(posedge clk);
    @(negedge clk) rst = 0;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (ret !== 32'h0) begin fails++; $display("FAIL arst_late got %h exp %h", ret, 32'h0); end
    do_cmd(READ_ACC, 32'd2, 32'd0);
    tests++; if (ret !== 32'h0) begin fails++; $display("FAIL arst_acc2 got %h exp %h", ret, 32'h0); end
    do_cmd(READ_TAPS, 32'd0, 32'd0);
    tests++; if (ret !== 32'h0) begin fails++; $display("FAIL arst_taps got %h exp %h", ret, 32'h0); end
    do_mac(32'h01010101, 32'h01010101);
    tests++; if (ret !== 32'd4) begin fails++; $display("FAIL arst_sel0_mac got %h exp %h", ret, 32'd4); end
  endtask

  initial begin
    test_reset;
    test_mac_basic;
    test_offset;
    test_sel_taps;
    test_back_to_back;
    test_async_reset;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
